sram_width_adapter: RTL and testbench

- Parametrised bridge between a narrow byte-lane SRAM requester (Subservient-class core) and a wide single-port OpenRAM-style macro.
- Generalises the fixed 8-to-32 converter in three ways: configurable lane width/count and pad bits, a one-word read buffer that skips macro reads on hits, and a read-modify-write mode for macros without write masks.
- Sits between the core's SRAM port and the macro, one per macro.

---
 rtl/sram_width_adapter_if.sv | 40 ++++
 rtl/sram_width_adapter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sram_width_adapter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_width_adapter_if.sv
// ---------------------------------------------------------------------------
// sram_width_adapter_if
//
// Narrow byte-lane SRAM request bus between a small core and
// sram_width_adapter. Each transfer is a single lane access.
//
//   i_req    request valid (core -> adapter)
//   i_we     1 = write, 0 = read; meaningful only with i_req
//   i_addr   lane address, AW bits
//   i_wdata  lane write data, NW bits
//   i_inv    drop the adapter's read buffer at the next edge
//   o_ready  adapter can accept; a transfer happens on i_req & o_ready
//   o_rdata  lane read data, NW bits
//   o_rvalid one-cycle pulse marking o_rdata as valid
//
// Modports: master = requester (core), slave = adapter.
// ---------------------------------------------------------------------------
interface sram_width_adapter_if #(
  parameter int AW = 10,
  parameter int NW = 8
);
  logic          i_req;
  logic          i_we;
  logic [AW-1:0] i_addr;
  logic [NW-1:0] i_wdata;
  logic          i_inv;
  logic          o_ready;
  logic [NW-1:0] o_rdata;
  logic          o_rvalid;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_inv,
    input  o_ready, o_rdata, o_rvalid
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_inv,
    output o_ready, o_rdata, o_rvalid
  );
endinterface

// File: rtl/sram_width_adapter.sv
// ---------------------------------------------------------------------------
// sram_width_adapter
//
// Bridges a narrow byte-lane SRAM requester to a wide single-port
// OpenRAM-style macro. RATIO lanes of NW bits form one macro word; the
// macro word carries PAD extra bits on top, written as zero and ignored
// on read.
//
// A one-word read buffer holds the last word fetched from (or merged into)
// the macro, so reads to the same word are served without a macro access.
// When the macro has no write mask (HAS_WMASK = 0), partial writes are
// done as read-modify-write; a write to the buffered word is merged
// in place and written back in one cycle.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   bus             narrow request bus (sram_width_adapter_if.slave)
//   o_csb0          macro chip select, active low
//   o_web0          macro write enable, active low
//   o_wmask0        macro lane write mask (one bit per lane)
//   o_addr0         macro word address (lane address without lane bits)
//   o_din0          macro write data, MW bits
//   i_dout0         macro read data, valid the cycle after a read strobe
//
// Timing summary:
//   read hit   : IDLE, o_rvalid registered one cycle later, o_ready stays 1
//   read miss  : IDLE (strobe) -> RD (data bypassed from macro, o_rvalid)
//   write      : one cycle in IDLE, except an RMW miss:
//                IDLE (read strobe) -> RMW (merged write-back)
// ---------------------------------------------------------------------------
module sram_width_adapter #(
  parameter  int AW        = 10,
  parameter  int NW        = 8,
  parameter  int RATIO     = 4,
  parameter  int PAD       = 1,
  parameter  int HAS_WMASK = 1,
  localparam int LW        = $clog2(RATIO),
  localparam int DW        = NW * RATIO,
  localparam int MW        = DW + PAD,
  localparam int WW        = AW - LW
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sram_width_adapter_if.slave  bus,
  output logic                 o_csb0,
  output logic                 o_web0,
  output logic [RATIO-1:0]     o_wmask0,
  output logic [WW-1:0]        o_addr0,
  output logic [MW-1:0]        o_din0,
  input  logic [MW-1:0]        i_dout0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RMW  = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Lane helpers
  // -------------------------------------------------------------------------
  function automatic logic [NW-1:0] get_lane(input logic [DW-1:0] w,
                                             input logic [LW-1:0] l);
    return w[int'(l)*NW +: NW];
  endfunction

  function automatic logic [DW-1:0] put_lane(input logic [DW-1:0] w,
                                             input logic [LW-1:0] l,
                                             input logic [NW-1:0] d);
    logic [DW-1:0] r;
    r = w;
    r[int'(l)*NW +: NW] = d;
    return r;
  endfunction

  function automatic logic [RATIO-1:0] lane_onehot(input logic [LW-1:0] l);
    logic [RATIO-1:0] r;
    r = '0;
    r[l] = 1'b1;
    return r;
  endfunction

  // Place a data word in the macro word with the pad bits held at zero.
  function automatic logic [MW-1:0] to_macro(input logic [DW-1:0] w);
    logic [MW-1:0] r;
    r = '0;
    r[DW-1:0] = w;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e         state_q,      state_d;
  logic           buf_valid_q,  buf_valid_d;
  logic           rvalid_q,     rvalid_d;
  logic [NW-1:0]  rdata_q,      rdata_d;
  logic [DW-1:0]  buf_data_q,   buf_data_d;
  logic [WW-1:0]  buf_tag_q,    buf_tag_d;
  logic [LW-1:0]  lane_q,       lane_d;
  logic [WW-1:0]  req_tag_q,    req_tag_d;
  logic [NW-1:0]  wdata_q,      wdata_d;

  // Macro strobes before the reset gate.
  logic             csb_c;
  logic             web_c;
  logic [RATIO-1:0] wmask_c;
  logic [WW-1:0]    addr_c;
  logic [MW-1:0]    din_c;

  logic [WW-1:0]  req_tag_w;
  logic [LW-1:0]  req_lane_w;
  logic [DW-1:0]  dout_w;
  logic           hit_w;
  logic [DW-1:0]  merged;

  assign req_tag_w  = bus.i_addr[AW-1:LW];
  assign req_lane_w = bus.i_addr[LW-1:0];
  assign dout_w     = i_dout0[DW-1:0];

  // Pad bits of the macro word carry nothing.
  logic unused_dout;
  assign unused_dout = ^i_dout0;

  // An invalidate in the same cycle forces a miss so the request never
  // sees data the requester has just declared stale.
  assign hit_w = buf_valid_q && (buf_tag_q == req_tag_w) && !bus.i_inv;

  // -------------------------------------------------------------------------
  // Next-state and macro strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    buf_data_d  = buf_data_q;
    buf_tag_d   = buf_tag_q;
    lane_d      = lane_q;
    req_tag_d   = req_tag_q;
    wdata_d     = wdata_q;
    merged      = '0;
    csb_c       = 1'b1;
    web_c       = 1'b1;
    wmask_c     = '0;
    addr_c      = req_tag_q;
    din_c       = '0;

    case (state_q)
      IDLE: begin
        addr_c = req_tag_w;
        if (bus.i_inv) begin
          buf_valid_d = 1'b0;
        end
        if (bus.i_req) begin
          if (!bus.i_we) begin
            if (hit_w) begin
              rvalid_d = 1'b1;
              rdata_d  = get_lane(buf_data_q, req_lane_w);
            end else begin
              csb_c     = 1'b0;
              lane_d    = req_lane_w;
              req_tag_d = req_tag_w;
              state_d   = RD;
            end
          end else if (HAS_WMASK != 0) begin
            // Masked macro: replicate the lane, let the mask pick it.
            csb_c   = 1'b0;
            web_c   = 1'b0;
            wmask_c = lane_onehot(req_lane_w);
            din_c   = to_macro({RATIO{bus.i_wdata}});
            if (hit_w) begin
              buf_data_d = put_lane(buf_data_q, req_lane_w, bus.i_wdata);
            end
          end else if (hit_w) begin
            // Unmasked macro, buffered word: merge locally, write whole word.
            merged     = put_lane(buf_data_q, req_lane_w, bus.i_wdata);
            csb_c      = 1'b0;
            web_c      = 1'b0;
            wmask_c    = '1;
            din_c      = to_macro(merged);
            buf_data_d = merged;
          end else begin
            // Unmasked macro, unknown word: fetch it first.
            csb_c     = 1'b0;
            lane_d    = req_lane_w;
            req_tag_d = req_tag_w;
            wdata_d   = bus.i_wdata;
            state_d   = RMW;
          end
        end
      end

      RD: begin
        buf_data_d  = dout_w;
        buf_tag_d   = req_tag_q;
        buf_valid_d = !bus.i_inv;
        rdata_d     = get_lane(dout_w, lane_q);
        state_d     = IDLE;
      end

      RMW: begin
        merged      = put_lane(dout_w, lane_q, wdata_q);
        csb_c       = 1'b0;
        web_c       = 1'b0;
        wmask_c     = '1;
        din_c       = to_macro(merged);
        buf_data_d  = merged;
        buf_tag_d   = req_tag_q;
        buf_valid_d = !bus.i_inv;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Reset deselects the macro at once, even if a request is being driven.
  assign o_csb0   = csb_c | ~i_rst_n;
  assign o_web0   = web_c | ~i_rst_n;
  assign o_wmask0 = wmask_c;
  assign o_addr0  = addr_c;
  assign o_din0   = din_c;

  assign bus.o_ready  = (state_q == IDLE) && i_rst_n;
  // Misses return data straight from the macro in RD; hits from rdata_q.
  assign bus.o_rvalid = rvalid_q || (state_q == RD);
  assign bus.o_rdata  = (state_q == RD) ? get_lane(dout_w, lane_q) : rdata_q;

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Data registers (qualified by buf_valid_q / state_q, no reset needed)
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    buf_data_q <= buf_data_d;
    buf_tag_q  <= buf_tag_d;
    lane_q     <= lane_d;
    req_tag_q  <= req_tag_d;
    wdata_q    <= wdata_d;
  end

endmodule

// File: tb/tb_sram_width_adapter.sv
module tb_sram_width_adapter;
  localparam int AW = 10;
  localparam int NW = 8;
  localparam int MW = 33;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- DUT A: masked macro, DUT B: unmasked (RMW) ----------
  logic          req_a, we_a, inv_a, req_b, we_b, inv_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [NW-1:0] wdata_a, wdata_b;
  logic          csb_a, web_a, csb_b, web_b;
  logic [3:0]    mask_a, mask_b;
  logic [WW-1:0] addr0_a, addr0_b;
  logic [MW-1:0] din_a, din_b, dout_a, dout_b;

  sram_width_adapter_if #(.AW(AW), .NW(NW)) ifa ();
  sram_width_adapter_if #(.AW(AW), .NW(NW)) ifb ();

  assign ifa.i_req = req_a;  assign ifa.i_we = we_a;  assign ifa.i_addr = addr_a;
  assign ifa.i_wdata = wdata_a;  assign ifa.i_inv = inv_a;
  assign ifb.i_req = req_b;  assign ifb.i_we = we_b;  assign ifb.i_addr = addr_b;
  assign ifb.i_wdata = wdata_b;  assign ifb.i_inv = inv_b;

  sram_width_adapter #(.AW(AW), .NW(NW), .RATIO(4), .PAD(1), .HAS_WMASK(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa.slave),
    .o_csb0(csb_a), .o_web0(web_a), .o_wmask0(mask_a), .o_addr0(addr0_a),
    .o_din0(din_a), .i_dout0(dout_a));

  sram_width_adapter #(.AW(AW), .NW(NW), .RATIO(4), .PAD(1), .HAS_WMASK(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb.slave),
    .o_csb0(csb_b), .o_web0(web_b), .o_wmask0(mask_b), .o_addr0(addr0_b),
    .o_din0(din_b), .i_dout0(dout_b));

  // ---------------- DUT C: NW=16, RATIO=2, PAD=0 ------------------------
  logic          req_c;
  logic [AW-1:0] addr_c;
  logic          csb_c, web_c;
  logic [1:0]    unused_mask_c;
  logic [8:0]    addr0_c;
  logic [31:0]   unused_din_c, dout_c;

  sram_width_adapter_if #(.AW(AW), .NW(16)) ifc ();
  assign ifc.i_req = req_c;  assign ifc.i_we = 1'b0;  assign ifc.i_addr = addr_c;
  assign ifc.i_wdata = 16'h0;  assign ifc.i_inv = 1'b0;

  sram_width_adapter #(.AW(AW), .NW(16), .RATIO(2), .PAD(0), .HAS_WMASK(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifc.slave),
    .o_csb0(csb_c), .o_web0(web_c), .o_wmask0(unused_mask_c), .o_addr0(addr0_c),
    .o_din0(unused_din_c), .i_dout0(dout_c));

  // ---------------- Macro models ----------------------------------------
  logic [MW-1:0] mem_a [256];
  logic [MW-1:0] mem_b [256];
  logic [MW-1:0] init_vals [256];
  logic          init_go;
  int acc_a = 0;
  int acc_b = 0;
  int acc_c = 0;

  // Macro A honours the lane mask.
  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_vals[i];
    end else if (!csb_a) begin
      acc_a <= acc_a + 1;
      if (!web_a) begin
        for (int l = 0; l < 4; l++)
          if (mask_a[l]) mem_a[addr0_a][l*8 +: 8] <= din_a[l*8 +: 8];
        mem_a[addr0_a][32] <= din_a[32];
      end else begin
        dout_a <= mem_a[addr0_a];
      end
    end
  end

  // Macro B ignores the mask entirely.
  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_vals[i];
    end else if (!csb_b) begin
      acc_b <= acc_b + 1;
      if (!web_b) mem_b[addr0_b] <= din_b;
      else        dout_b <= mem_b[addr0_b];
    end
  end

  always @(posedge clk) begin
    if (!csb_c) begin
      acc_c <= acc_c + 1;
      if (web_c) dout_c <= (addr0_c == 9'd0) ? 32'h1234ABCD : 32'h0;
    end
  end

  // ---------------- Reference model -------------------------------------
  logic [7:0] mm [2][1024];   // lane contents per macro
  int         bw [2];         // word held in the read buffer, -1 if none

  // ---------------- Snapshot of one DUT's outputs -----------------------
  logic          s_csb, s_web, s_ready, s_rvalid;
  logic [3:0]    s_mask;
  logic [WW-1:0] s_addr0;
  logic [MW-1:0] s_din;
  logic [NW-1:0] s_rdata;

  task automatic snap(input int sel);
    if (sel == 0) begin
      s_csb = csb_a; s_web = web_a; s_mask = mask_a; s_addr0 = addr0_a; s_din = din_a;
      s_ready = ifa.o_ready; s_rvalid = ifa.o_rvalid; s_rdata = ifa.o_rdata;
    end else begin
      s_csb = csb_b; s_web = web_b; s_mask = mask_b; s_addr0 = addr0_b; s_din = din_b;
      s_ready = ifb.o_ready; s_rvalid = ifb.o_rvalid; s_rdata = ifb.o_rdata;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [NW-1:0] wd, input logic inv);
    if (sel == 0) begin req_a = req; we_a = we; addr_a = addr; wdata_a = wd; inv_a = inv; end
    else          begin req_b = req; we_b = we; addr_b = addr; wdata_b = wd; inv_b = inv; end
  endtask

  // One complete transaction on DUT sel, checked against the model.
  task automatic do_req(input int sel, input logic we, input logic [AW-1:0] addr,
                        input logic [NW-1:0] wd, input logic inv,
                        output logic [NW-1:0] rd, output logic [MW-1:0] din_o);
    int word, lane, acc0, exp_acc;
    bit hit, extra;
    logic [31:0] mw;
    rd = '0;
    din_o = '0;
    @(negedge clk);
    word = int'(addr) / 4;
    lane = int'(addr) % 4;
    hit  = !inv && (bw[sel] == word);
    for (int k = 0; k < 4; k++) mw[k*8 +: 8] = mm[sel][word*4 + k];
    if (we) mw[lane*8 +: 8] = wd;
    acc0  = (sel == 0) ? acc_a : acc_b;
    extra = !we ? !hit : (sel == 1 && !hit);
    drive(sel, 1'b1, we, addr, wd, inv);
    #1 snap(sel);
    check("ready_idle", s_ready, 1);
    check("rvalid_idle", s_rvalid, 0);
    if (!we) begin
      check("rd_csb", s_csb, hit);
      if (!hit) begin
        check("rd_web", s_web, 1);
        check("rd_addr0", s_addr0, word);
      end
    end else if (sel == 0) begin
      check("wm_csb", s_csb, 0);
      check("wm_web", s_web, 0);
      check("wm_mask", s_mask, 4'b0001 << lane);
      check("wm_din", s_din, {1'b0, {4{wd}}});
      check("wm_addr0", s_addr0, word);
      din_o = s_din;
    end else if (hit) begin
      check("wh_csb", s_csb, 0);
      check("wh_web", s_web, 0);
      check("wh_mask", s_mask, 4'hF);
      check("wh_din", s_din, {1'b0, mw});
      check("wh_addr0", s_addr0, word);
      din_o = s_din;
    end else begin
      check("rmw_rd_csb", s_csb, 0);
      check("rmw_rd_web", s_web, 1);
      check("rmw_rd_addr0", s_addr0, word);
    end
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, addr, wd, 1'b0);
    #1 snap(sel);
    if (!we) begin
      check("rd_rvalid", s_rvalid, 1);
      check("rd_rdata", s_rdata, mm[sel][addr]);
      check("rd_ready", s_ready, hit);
      rd = s_rdata;
    end else if (sel == 1 && !hit) begin
      check("rmw_ready", s_ready, 0);
      check("rmw_csb", s_csb, 0);
      check("rmw_web", s_web, 0);
      check("rmw_mask", s_mask, 4'hF);
      check("rmw_din", s_din, {1'b0, mw});
      check("rmw_addr0", s_addr0, word);
      check("rmw_rvalid", s_rvalid, 0);
      din_o = s_din;
    end else begin
      check("wr_rvalid", s_rvalid, 0);
      check("wr_ready", s_ready, 1);
    end
    if (extra) begin
      @(posedge clk);
      #1;
    end
    exp_acc = we ? ((sel == 1 && !hit) ? 2 : 1) : (hit ? 0 : 1);
    check("macro_accesses", ((sel == 0) ? acc_a : acc_b) - acc0, exp_acc);
    if (we) mm[sel][addr] = wd;
    if (!we || (sel == 1 && !hit)) bw[sel] = word;
    else if (inv) bw[sel] = -1;
  endtask

  // ---------------- Stimulus --------------------------------------------
  initial begin
    logic [NW-1:0] rd;
    logic [MW-1:0] dino;
    int a0, b0;

    for (int i = 0; i < 256; i++) init_vals[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
    init_vals[1] = 33'h0_DDCCBBAA;
    init_vals[2] = 33'h0_11223344;
    for (int w = 0; w < 256; w++)
      for (int l = 0; l < 4; l++) begin
        mm[0][w*4 + l] = init_vals[w][l*8 +: 8];
        mm[1][w*4 + l] = init_vals[w][l*8 +: 8];
      end
    bw[0] = -1;
    bw[1] = -1;

    // Reset, with a request held on A to show the macro stays deselected.
    rst_n = 1'b0;
    init_go = 1'b1;
    drive(0, 1'b1, 1'b0, 10'h005, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
    req_c = 1'b0;
    addr_c = '0;
    #2;
    check("rst_csb_a", csb_a, 1);
    check("rst_csb_b", csb_b, 1);
    @(posedge clk);
    @(negedge clk);
    init_go = 1'b0;
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_a", ifa.o_ready, 1);
    check("rst_ready_b", ifb.o_ready, 1);
    check("rst_rvalid_a", ifa.o_rvalid, 0);
    check("rst_rdata_a", ifa.o_rdata, 0);
    check("rst_csb_idle", csb_a, 1);

    // Directed: fill, hit, masked write, write hit, invalidate.
    do_req(0, 1'b0, 10'h005, 8'h00, 1'b0, rd, dino);
    check("plan_rd_005", rd, 8'hBB);
    do_req(0, 1'b0, 10'h006, 8'h00, 1'b0, rd, dino);
    check("plan_hit_006", rd, 8'hCC);
    do_req(0, 1'b1, 10'h007, 8'h5A, 1'b0, rd, dino);
    check("plan_wm_din", dino, 33'h0_5A5A5A5A);
    do_req(0, 1'b0, 10'h007, 8'h00, 1'b0, rd, dino);
    check("plan_hit_007", rd, 8'h5A);
    do_req(0, 1'b0, 10'h004, 8'h00, 1'b1, rd, dino);
    check("plan_inv_004", rd, 8'hAA);

    // Directed: read-modify-write on the unmasked macro.
    do_req(1, 1'b1, 10'h009, 8'hEE, 1'b0, rd, dino);
    check("plan_rmw_din", dino, 33'h0_1122EE44);
    do_req(1, 1'b1, 10'h008, 8'h77, 1'b0, rd, dino);
    check("plan_wh_din", dino, 33'h0_1122EE77);
    do_req(1, 1'b0, 10'h00A, 8'h00, 1'b0, rd, dino);
    check("plan_hit_00a", rd, 8'h22);

    // Randomised traffic on both adapters.
    for (int k = 0; k < 300; k++) begin
      do_req($urandom_range(0, 1), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 63)), 8'($urandom),
             ($urandom_range(0, 7) == 0), rd, dino);
    end

    // Reset while A is in RD and B is in RMW.
    a0 = acc_a;
    b0 = acc_b;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 10'h3F0, 8'h00, 1'b0);
    drive(1, 1'b1, 1'b1, 10'h3F6, 8'h99, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
    #1;
    check("abort_busy_a", ifa.o_ready, 0);
    check("abort_busy_b", ifb.o_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_csb_a", csb_a, 1);
    check("abort_csb_b", csb_b, 1);
    check("abort_web_b", web_b, 1);
    check("abort_rvalid_a", ifa.o_rvalid, 0);
    @(posedge clk);
    #1;
    check("abort_acc_a", acc_a - a0, 1);
    check("abort_acc_b", acc_b - b0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready_a", ifa.o_ready, 1);
    check("abort_ready_b", ifb.o_ready, 1);
    check("abort_rdata_a", ifa.o_rdata, 0);
    bw[0] = -1;
    bw[1] = -1;
    // Buffers must be empty, and the aborted write must not have landed.
    do_req(1, 1'b0, 10'h3F6, 8'h00, 1'b0, rd, dino);
    do_req(0, 1'b0, 10'h3F0, 8'h00, 1'b0, rd, dino);

    // Narrow 16-bit lanes, two per word, no pad.
    @(negedge clk);
    req_c = 1'b1;
    addr_c = 10'h001;
    #1;
    check("c_rd_csb", csb_c, 0);
    check("c_rd_addr0", addr0_c, 0);
    @(posedge clk);
    @(negedge clk);
    req_c = 1'b0;
    #1;
    check("c_rvalid", ifc.o_rvalid, 1);
    check("c_rdata_hi", ifc.o_rdata, 16'h1234);
    check("c_ready_rd", ifc.o_ready, 0);
    @(negedge clk);
    req_c = 1'b1;
    addr_c = 10'h000;
    #1;
    check("c_hit_csb", csb_c, 1);
    @(posedge clk);
    @(negedge clk);
    req_c = 1'b0;
    #1;
    check("c_hit_rvalid", ifc.o_rvalid, 1);
    check("c_rdata_lo", ifc.o_rdata, 16'hABCD);
    check("c_acc", acc_c, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end
endmodule
